// File: rtl/gobou_layer_sched_if.sv
// Host-configuration and core-controller signals of the gobou layer scheduler.
// The master modport is the scheduler's view; slave is the host/core side.
interface gobou_layer_sched_if #(
    parameter int LAYERLOG      = 2,
    parameter int IMGSIZE       = 16,
    parameter int GOBOU_NETSIZE = 16,
    parameter int LWIDTH        = 10
);
    logic                     cfg_we;
    logic [LAYERLOG-1:0]      cfg_layer;
    logic [2:0]               cfg_field;
    logic [31:0]              cfg_wdata;
    logic [LAYERLOG:0]        num_layers;
    logic                     start;
    logic                     core_ack;
    logic                     req;
    logic [IMGSIZE-1:0]       in_offset;
    logic [IMGSIZE-1:0]       out_offset;
    logic [GOBOU_NETSIZE-1:0] net_offset;
    logic [LWIDTH-1:0]        total_out;
    logic [LWIDTH-1:0]        total_in;
    logic                     busy;
    logic                     done;
    logic [LAYERLOG-1:0]      cur_layer;
    logic                     cfg_err;

    modport master (
        input  cfg_we, cfg_layer, cfg_field, cfg_wdata, num_layers, start, core_ack,
        output req, in_offset, out_offset, net_offset, total_out, total_in,
               busy, done, cur_layer, cfg_err
    );

    modport slave (
        output cfg_we, cfg_layer, cfg_field, cfg_wdata, num_layers, start, core_ack,
        input  req, in_offset, out_offset, net_offset, total_out, total_in,
               busy, done, cur_layer, cfg_err
    );
endinterface

// File: rtl/gobou_layer_sched.sv
// Layer scheduler: holds a table of layer descriptors and issues them one by one
// to the gobou core controller over its req/ack handshake.
module gobou_layer_sched #(
    parameter int MAXLAYER      = 4,
    parameter int LAYERLOG      = 2,
    parameter int IMGSIZE       = 16,
    parameter int GOBOU_NETSIZE = 16,
    parameter int LWIDTH        = 10
) (
    input  logic                clk,
    input  logic                xrst,
    gobou_layer_sched_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_WAIT_LO,
        S_WAIT_HI,
        S_NEXT,
        S_DONE
    } state_t;

    state_t                   state_q, state_d;
    logic [LAYERLOG:0]        count_q, count_d;
    logic [LAYERLOG:0]        num_clamped;
    logic [LAYERLOG-1:0]      cur_layer_q, cur_layer_d;
    logic                     req_q, req_d;
    logic                     done_q, done_d;
    logic                     busy_q, busy_d;
    logic                     cfg_err_q, cfg_err_d;
    logic [IMGSIZE-1:0]       in_offset_q, in_offset_d;
    logic [IMGSIZE-1:0]       out_offset_q, out_offset_d;
    logic [GOBOU_NETSIZE-1:0] net_offset_q, net_offset_d;
    logic [LWIDTH-1:0]        total_out_q, total_out_d;
    logic [LWIDTH-1:0]        total_in_q, total_in_d;

    logic [IMGSIZE-1:0]       slot_in   [MAXLAYER];
    logic [IMGSIZE-1:0]       slot_out  [MAXLAYER];
    logic [GOBOU_NETSIZE-1:0] slot_net  [MAXLAYER];
    logic [LWIDTH-1:0]        slot_tout [MAXLAYER];
    logic [LWIDTH-1:0]        slot_tin  [MAXLAYER];

    logic tbl_we;
    logic unused_wdata;

    // Table writes are only honoured while no run is in progress.
    assign tbl_we       = bus.cfg_we && (state_q == S_IDLE);
    assign unused_wdata = ^bus.cfg_wdata;

    genvar gi;
    generate
        for (gi = 0; gi < MAXLAYER; gi++) begin : g_slot
            logic [IMGSIZE-1:0]       in_q, in_d;
            logic [IMGSIZE-1:0]       out_q, out_d;
            logic [GOBOU_NETSIZE-1:0] net_q, net_d;
            logic [LWIDTH-1:0]        tout_q, tout_d;
            logic [LWIDTH-1:0]        tin_q, tin_d;
            logic                     sel;

            assign sel = tbl_we && (bus.cfg_layer == LAYERLOG'(gi));

            always_comb begin
                in_d   = in_q;
                out_d  = out_q;
                net_d  = net_q;
                tout_d = tout_q;
                tin_d  = tin_q;
                if (sel) begin
                    case (bus.cfg_field)
                        3'd0:    in_d   = bus.cfg_wdata[IMGSIZE-1:0];
                        3'd1:    out_d  = bus.cfg_wdata[IMGSIZE-1:0];
                        3'd2:    net_d  = bus.cfg_wdata[GOBOU_NETSIZE-1:0];
                        3'd3:    tout_d = bus.cfg_wdata[LWIDTH-1:0];
                        3'd4:    tin_d  = bus.cfg_wdata[LWIDTH-1:0];
                        default: begin end
                    endcase
                end
            end

            always_ff @(posedge clk or negedge xrst) begin
                if (!xrst) begin
                    in_q   <= '0;
                    out_q  <= '0;
                    net_q  <= '0;
                    tout_q <= '0;
                    tin_q  <= '0;
                end else begin
                    in_q   <= in_d;
                    out_q  <= out_d;
                    net_q  <= net_d;
                    tout_q <= tout_d;
                    tin_q  <= tin_d;
                end
            end

            assign slot_in[gi]   = in_q;
            assign slot_out[gi]  = out_q;
            assign slot_net[gi]  = net_q;
            assign slot_tout[gi] = tout_q;
            assign slot_tin[gi]  = tin_q;
        end
    endgenerate

    assign num_clamped = (bus.num_layers > (LAYERLOG+1)'(MAXLAYER)) ?
                         (LAYERLOG+1)'(MAXLAYER) : bus.num_layers;

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        cur_layer_d  = cur_layer_q;
        in_offset_d  = in_offset_q;
        out_offset_d = out_offset_q;
        net_offset_d = net_offset_q;
        total_out_d  = total_out_q;
        total_in_d   = total_in_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    count_d     = num_clamped;
                    cur_layer_d = '0;
                    state_d     = (num_clamped == '0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                in_offset_d  = slot_in[cur_layer_q];
                out_offset_d = slot_out[cur_layer_q];
                net_offset_d = slot_net[cur_layer_q];
                total_out_d  = slot_tout[cur_layer_q];
                total_in_d   = slot_tin[cur_layer_q];
                // A zero-sized layer is skipped so the core never sees a zero total.
                if ((slot_tout[cur_layer_q] == '0) || (slot_tin[cur_layer_q] == '0))
                    state_d = S_NEXT;
                else
                    state_d = S_ISSUE;
            end
            S_ISSUE:   state_d = S_WAIT_LO;
            S_WAIT_LO: if (!bus.core_ack) state_d = S_WAIT_HI;
            S_WAIT_HI: if (bus.core_ack) state_d = S_NEXT;
            S_NEXT: begin
                if (({1'b0, cur_layer_q} + (LAYERLOG+1)'(1)) == count_q) begin
                    state_d = S_DONE;
                end else begin
                    cur_layer_d = cur_layer_q + LAYERLOG'(1);
                    state_d     = S_LOAD;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Status outputs are registered from the next state so they line up with it.
        req_d     = (state_d == S_ISSUE);
        done_d    = (state_d == S_DONE);
        busy_d    = (state_d != S_IDLE);
        cfg_err_d = (state_q != S_IDLE) && (bus.cfg_we || bus.start);
    end

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            state_q      <= S_IDLE;
            count_q      <= '0;
            cur_layer_q  <= '0;
            req_q        <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            cfg_err_q    <= 1'b0;
            in_offset_q  <= '0;
            out_offset_q <= '0;
            net_offset_q <= '0;
            total_out_q  <= '0;
            total_in_q   <= '0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            cur_layer_q  <= cur_layer_d;
            req_q        <= req_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
            cfg_err_q    <= cfg_err_d;
            in_offset_q  <= in_offset_d;
            out_offset_q <= out_offset_d;
            net_offset_q <= net_offset_d;
            total_out_q  <= total_out_d;
            total_in_q   <= total_in_d;
        end
    end

    assign bus.req        = req_q;
    assign bus.done       = done_q;
    assign bus.busy       = busy_q;
    assign bus.cfg_err    = cfg_err_q;
    assign bus.cur_layer  = cur_layer_q;
    assign bus.in_offset  = in_offset_q;
    assign bus.out_offset = out_offset_q;
    assign bus.net_offset = net_offset_q;
    assign bus.total_out  = total_out_q;
    assign bus.total_in   = total_in_q;

endmodule

// File: doc/gobou_layer_sched.md
# gobou_layer_sched

Layer scheduler for the gobou fully-connected core controller. Holds a host-written table of up to MAXLAYER layer descriptors and, on `start`, issues them to the core controller one at a time over its `req`/`ack` handshake. It supplies the per-layer offsets and sizes, waits for each layer to finish, then advances. The block sits between the host register interface and the core controller, so a multi-layer network runs without host involvement between layers.

## Interface
- MAXLAYER, 4, number of descriptor slots
- LAYERLOG, 2, slot index width, equal to clog2(MAXLAYER)
- IMGSIZE, GOBOU_NETSIZE, LWIDTH: the codebase-wide widths from gobou.svh, not overridden here
- clk  in  1  clock
- xrst  in  1  reset. One clock; reset is asynchronous and active-low.
- cfg_we  in  1  descriptor write strobe
- cfg_layer  in  LAYERLOG  slot being written
- cfg_field  in  3  0 in_offset, 1 out_offset, 2 net_offset, 3 total_out, 4 total_in; codes 5..7 are ignored
- cfg_wdata  in  32  write data, truncated to the field width
- num_layers  in  LAYERLOG+1  number of layers to run; sampled on accepted `start`
- start  in  1  one-cycle run request
- core_ack  in  1  core controller `ack`: high when idle, low while busy
- req  out  1  one-cycle request to the core
- in_offset, out_offset  out  IMGSIZE  descriptor operands to the core
- net_offset  out  GOBOU_NETSIZE  descriptor operand to the core
- total_out, total_in  out  LWIDTH  descriptor operands to the core
- busy  out  1  run in progress
- done  out  1  one-cycle pulse at the end of a run
- cur_layer  out  LAYERLOG  slot currently issued
- cfg_err  out  1  one-cycle pulse when a write or start is rejected

## Operation
- **Descriptor table:** MAXLAYER × 5 registers.
  - Written when `cfg_we && !busy`.
  - `cfg_we` while busy is dropped and pulses `cfg_err`; the table is unchanged.
- **Start rules:**
  - `start` while busy is ignored and pulses `cfg_err`.
  - A `num_layers` value greater than MAXLAYER is clamped to MAXLAYER.
- **States:**
  - S_IDLE: on `start`, latch `num_layers` and set `cur_layer`=0. If count = 0, go to S_DONE; otherwise go to S_LOAD.
  - S_LOAD: copy slot `cur_layer` to the operand output registers. If `total_out`==0 or `total_in`==0, go to S_NEXT, because the layer is skipped and the core must never see a zero total. Otherwise go to S_ISSUE.
  - S_ISSUE: `req`=1 for exactly this cycle, then go to S_WAIT_LO.
  - S_WAIT_LO: wait for `core_ack`==0. This stops a stale idle-high `ack` from being taken as completion.
  - S_WAIT_HI: wait for `core_ack`==1, then go to S_NEXT.
  - S_NEXT: if `cur_layer`+1 == count, go to S_DONE; otherwise increment `cur_layer` and go to S_LOAD.
  - S_DONE: `done`=1 for one cycle, then go to S_IDLE.
- **Operand stability:** operand outputs hold their value from S_LOAD until the next S_LOAD. The core latches its offsets on both `req` and `ack`, so the operands stay valid across the handshake.
- **`busy`:** high in every state except S_IDLE.

## Timing
- **Reset values:**
  - `req`, `busy`, `done`, `cfg_err`, `cur_layer` and all operand outputs are 0.
  - All table entries are 0. State is S_IDLE.
  - Reset takes effect immediately, including mid-run. `req` drops asynchronously, and no `done` is issued for the aborted run.
- **Start to request:** `start` is sampled at edge 0. S_LOAD runs in cycle 1. `req` is high in cycle 2 with operands valid since cycle 2.
- **Acknowledge path:**
  - The core lowers `ack` one cycle after `req`.
  - The `ack` rise is seen at edge n. S_NEXT runs in cycle n+1.
  - The next layer's `req` comes at n+3; the last layer's `done` comes at n+2.
- **Skipped layer:** costs 2 cycles (S_LOAD, S_NEXT) with no `req`.
- **Empty run:** `num_layers`=0 gives `done` in cycle 1 with no `req`.
- **Simultaneous events:** if `cfg_we` and `start` arrive in the same idle cycle, the write is applied first. Slot 0 loads the new value in S_LOAD.
- **Outputs:** all registered. No combinational path from inputs to outputs.

## Test plan
- **Two layers:** slot0 = {in 0, out 100, net 0, tout 32, tin 64}; slot1 = {100, 200, 520, 10, 32}; `num_layers`=2, `start` → `req` in cycle 2 with slot0 values. With a model core, the second `req` comes 3 cycles after the first `ack` rise. `done` comes 2 cycles after the second rise. Exactly 2 `req` pulses in total.
- **Skip:** slot1 `total_in`=0, `num_layers`=3 → `req` issued only for slots 0 and 2; `cur_layer` passes through 1 for 2 cycles.
- **Stale ack:** hold `core_ack` high for 5 cycles after `req`, then low for 20, then high → scheduler stays in S_WAIT_LO until the drop and does not advance early.
- **Rejections while busy:** `cfg_we` and `start` during a run → `cfg_err` pulses once per attempt; the table and `cur_layer` are unchanged; the run completes normally.
- **Edge counts:** `num_layers`=0 → `done` in cycle 1, no `req`. `num_layers`=7 with MAXLAYER=4 → exactly 4 requests.
- **Reset mid-operation:** assert `xrst` low during S_WAIT_HI → all outputs go to 0 immediately. After release, `start` runs from slot 0, and the table reads back zeros (so slot 0 is skipped).
